// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state numbers, ALU op codes and condition codes for the control sequencer
//
// Shared by control_sequencer and cond_eval. State numbers match the
// instruction encoder's 6-bit output so DECODE can dispatch on it directly.
package ctrl_pkg;

    typedef enum logic [5:0] {
        ST_RESET   = 6'd0,
        ST_FETCH0  = 6'd1,
        ST_FETCH1  = 6'd2,
        ST_FETCH2  = 6'd3,
        ST_DECODE  = 6'd4,
        ST_ADD_RR  = 6'd10,
        ST_ADD_IMM = 6'd11,
        ST_ADD_SH  = 6'd12,
        ST_CMP     = 6'd13,
        ST_MOV     = 6'd14,
        ST_LDR0    = 6'd20,
        ST_LDR1    = 6'd21,
        ST_LDR2    = 6'd22,
        ST_STR0    = 6'd25,
        ST_STR1    = 6'd26,
        ST_STR2    = 6'd27,
        ST_B       = 6'd30,
        ST_FAULT   = 6'd63
    } state_e;

    // Code 0 is reserved for "no operation" so an idle decode drives all zeros.
    typedef enum logic [3:0] {
        ALU_NONE  = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_PASSB = 4'd3,
        ALU_PC4   = 4'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Encoder outputs that DECODE is allowed to dispatch to.
    function automatic logic is_exec_state(input logic [5:0] s);
        case (s)
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd20, 6'd25, 6'd30: is_exec_state = 1'b1;
            default:                                                 is_exec_state = 1'b0;
        endcase
    endfunction

    // States that stall on memory-operation-complete.
    function automatic logic is_wait_state(input logic [5:0] s);
        is_wait_state = (s == 6'd3) || (s == 6'd21) || (s == 6'd27);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - ARM condition field evaluation against NZCV
//
// Ports:
//   ir_cond   in  4  IR[31:28]
//   flags     in  4  {N,Z,C,V}
//   cond_pass out 1  instruction may execute
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] ir_cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);

    logic n_f, z_f, c_f, v_f;

    always_comb begin
        {n_f, z_f, c_f, v_f} = flags;
        cond_pass = 1'b0;
        case (ir_cond)
            COND_EQ: cond_pass = z_f;
            COND_NE: cond_pass = !z_f;
            COND_CS: cond_pass = c_f;
            COND_CC: cond_pass = !c_f;
            COND_MI: cond_pass = n_f;
            COND_PL: cond_pass = !n_f;
            COND_VS: cond_pass = v_f;
            COND_VC: cond_pass = !v_f;
            COND_HI: cond_pass = c_f && !z_f;
            COND_LS: cond_pass = !c_f || z_f;
            COND_GE: cond_pass = (n_f == v_f);
            COND_LT: cond_pass = (n_f != v_f);
            COND_GT: cond_pass = !z_f && (n_f == v_f);
            COND_LE: cond_pass = z_f || (n_f != v_f);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microprogrammed fetch/decode/execute sequencer for the RISC datapath
//
// Optional build macro: MOC_TIMEOUT_EN adds a moc watchdog (parameter
// TIMEOUT_CYC) that parks the sequencer in FAULT (state 63) until reset.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   enc_state  in  6      encoder state number for the current IR
//   ir_cond    in  4      IR[31:28]
//   flags      in  4      {N,Z,C,V}
//   moc        in  1      memory operation complete
//   state      out 6      current state number
//   ld_mar, ld_mdr, ld_ir, ld_pc, rf_we, flags_we   register load strobes
//   mem_en, mem_rw        memory request, mem_rw 1 = read
//   mar_sel, pc_sel, rf_src, alu_op                 datapath selects
//   fault      out 1      moc timeout (always 0 without MOC_TIMEOUT_EN)
module control_sequencer
    import ctrl_pkg::*;
`ifdef MOC_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 15
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] enc_state,
    input  logic [3:0] ir_cond,
    input  logic [3:0] flags,
    input  logic       moc,
    output logic [5:0] state,
    output logic       ld_mar,
    output logic       ld_mdr,
    output logic       ld_ir,
    output logic       ld_pc,
    output logic       rf_we,
    output logic       flags_we,
    output logic       mem_en,
    output logic       mem_rw,
    output logic       mar_sel,
    output logic       pc_sel,
    output logic       rf_src,
    output logic [3:0] alu_op,
    output logic       fault
);

    state_e state_q, state_d;
    logic   cond_pass;

    cond_eval u_cond_eval (
        .ir_cond   (ir_cond),
        .flags     (flags),
        .cond_pass (cond_pass)
    );

`ifdef MOC_TIMEOUT_EN
    localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT_CYC);
    logic [4:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
`ifdef MOC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MOC_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = ST_FETCH0;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH0;
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: state_d = ST_FETCH2;
            ST_FETCH2: state_d = moc ? ST_DECODE : ST_FETCH2;
            // Failed condition or unknown encoding: skip straight to the next fetch.
            ST_DECODE: state_d = (cond_pass && is_exec_state(enc_state))
                               ? state_e'(enc_state) : ST_FETCH0;
            ST_LDR0:   state_d = ST_LDR1;
            ST_LDR1:   state_d = moc ? ST_LDR2 : ST_LDR1;
            ST_STR0:   state_d = ST_STR1;
            ST_STR1:   state_d = ST_STR2;
            ST_STR2:   state_d = moc ? ST_FETCH0 : ST_STR2;
`ifdef MOC_TIMEOUT_EN
            ST_FAULT:  state_d = ST_FAULT;
`endif
            default:   state_d = ST_FETCH0;
        endcase

`ifdef MOC_TIMEOUT_EN
        cnt_d = cnt_q;
        if (is_wait_state(state_q) && !moc) begin
            if (cnt_q + 5'd1 == TIMEOUT_LIM) begin
                state_d = ST_FAULT;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
        // Each fresh wait gets a full budget.
        if (is_wait_state(state_d) && (state_d != state_q)) begin
            cnt_d = '0;
        end
`endif
    end

    // Strobe decode. ld_ir and ld_mdr are the only moc-qualified strobes: they
    // capture the memory data in the same cycle the access completes.
    always_comb begin
        ld_mar   = 1'b0;
        ld_mdr   = 1'b0;
        ld_ir    = 1'b0;
        ld_pc    = 1'b0;
        rf_we    = 1'b0;
        flags_we = 1'b0;
        mem_en   = 1'b0;
        mem_rw   = 1'b0;
        mar_sel  = 1'b0;
        pc_sel   = 1'b0;
        rf_src   = 1'b0;
        alu_op   = ALU_NONE;
        fault    = 1'b0;
        case (state_q)
            ST_FETCH0: ld_mar = 1'b1;
            ST_FETCH1: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                ld_pc  = 1'b1;
                alu_op = ALU_PC4;
            end
            ST_FETCH2: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                ld_ir  = moc;
            end
            ST_ADD_RR, ST_ADD_IMM, ST_ADD_SH: begin
                rf_we  = 1'b1;
                alu_op = ALU_ADD;
            end
            ST_CMP: begin
                flags_we = 1'b1;
                alu_op   = ALU_SUB;
            end
            ST_MOV: begin
                rf_we  = 1'b1;
                alu_op = ALU_PASSB;
            end
            ST_LDR0, ST_STR0: begin
                ld_mar  = 1'b1;
                mar_sel = 1'b1;
                alu_op  = ALU_ADD;
            end
            ST_LDR1: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                ld_mdr = moc;
            end
            ST_LDR2: begin
                rf_we  = 1'b1;
                rf_src = 1'b1;
            end
            ST_STR1:   ld_mdr = 1'b1;
            ST_STR2:   mem_en = 1'b1;
            ST_B: begin
                ld_pc  = 1'b1;
                pc_sel = 1'b1;
            end
`ifdef MOC_TIMEOUT_EN
            ST_FAULT:  fault = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
    import ctrl_pkg::*;

    localparam int TCYC = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] enc_state;
    logic [3:0] ir_cond;
    logic [3:0] flags;
    logic       moc;
    logic [5:0] state;
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, rf_we, flags_we;
    logic       mem_en, mem_rw, mar_sel, pc_sel, rf_src;
    logic [3:0] alu_op;
    logic       fault;

    control_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enc_state (enc_state),
        .ir_cond   (ir_cond),
        .flags     (flags),
        .moc       (moc),
        .state     (state),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .ld_ir     (ld_ir),
        .ld_pc     (ld_pc),
        .rf_we     (rf_we),
        .flags_we  (flags_we),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mar_sel   (mar_sel),
        .pc_sel    (pc_sel),
        .rf_src    (rf_src),
        .alu_op    (alu_op),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [21:0] exp_q[$];
    int          st_q[$];
    bit          mq[$];
    bit          faulted;

    function automatic logic [21:0] dut_vec();
        return {state, ld_mar, ld_mdr, ld_ir, ld_pc, rf_we, flags_we, mem_en,
                mem_rw, mar_sel, pc_sel, rf_src, alu_op, fault};
    endfunction

    // Output table keyed on the cycle's state number and that cycle's moc.
    function automatic logic [21:0] exp_vec(input int s, input bit m);
        logic a_mar = 0, a_mdr = 0, a_ir = 0, a_pc = 0, a_rf = 0, a_fl = 0;
        logic a_en = 0, a_rw = 0, a_msel = 0, a_psel = 0, a_src = 0, a_f = 0;
        logic [3:0] a_alu = 4'd0;
        logic [5:0] s6 = 6'(s);
        case (s)
            1:          a_mar = 1;
            2:          begin a_en = 1; a_rw = 1; a_pc = 1; a_alu = ALU_PC4; end
            3:          begin a_en = 1; a_rw = 1; a_ir = m; end
            10, 11, 12: begin a_rf = 1; a_alu = ALU_ADD; end
            13:         begin a_fl = 1; a_alu = ALU_SUB; end
            14:         begin a_rf = 1; a_alu = ALU_PASSB; end
            20, 25:     begin a_mar = 1; a_msel = 1; a_alu = ALU_ADD; end
            21:         begin a_en = 1; a_rw = 1; a_mdr = m; end
            22:         begin a_rf = 1; a_src = 1; end
            26:         a_mdr = 1;
            27:         a_en = 1;
            30:         begin a_pc = 1; a_psel = 1; end
            63:         a_f = 1;
            default: ;
        endcase
        return {s6, a_mar, a_mdr, a_ir, a_pc, a_rf, a_fl, a_en, a_rw,
                a_msel, a_psel, a_src, a_alu, a_f};
    endfunction

    // Condition pass: the upper three bits pick a predicate, bit 0 inverts it.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        bit base;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return base ^ c[0];
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push_cyc(input int s, input bit m);
        st_q.push_back(s);
        mq.push_back(m);
    endtask

    task automatic push_wait(input int s, input int d);
`ifdef MOC_TIMEOUT_EN
        if (d >= TCYC) begin
            repeat (TCYC) push_cyc(s, 1'b0);
            repeat (5) push_cyc(63, rbit());
            faulted = 1'b1;
            return;
        end
`endif
        repeat (d) push_cyc(s, 1'b0);
        push_cyc(s, 1'b1);
    endtask

    // One instruction's cycle-by-cycle trace, from FETCH0 up to (not including) the next FETCH0.
    task automatic build(input int enc, input logic [3:0] c, input logic [3:0] f,
                         input int fd, input int md);
        st_q.delete();
        mq.delete();
        faulted = 1'b0;
        push_cyc(1, rbit());
        push_cyc(2, rbit());
        push_wait(3, fd);
        if (faulted) return;
        push_cyc(4, rbit());
        if (!ref_pass(c, f) || !(enc inside {10, 11, 12, 13, 14, 20, 25, 30})) return;
        if (enc == 20) begin
            push_cyc(20, rbit());
            push_wait(21, md);
            if (!faulted) push_cyc(22, rbit());
        end else if (enc == 25) begin
            push_cyc(25, rbit());
            push_cyc(26, rbit());
            push_wait(27, md);
        end else begin
            push_cyc(enc, rbit());
        end
    endtask

    task automatic play(input int enc, input logic [3:0] c, input logic [3:0] f, input int limit);
        for (int i = 0; i < st_q.size() && i < limit; i++) begin
            @(negedge clk);
            enc_state = 6'(enc);
            ir_cond   = c;
            flags     = f;
            moc       = mq[i];
            exp_q.push_back(exp_vec(st_q[i], mq[i]));
        end
    endtask

    task automatic run(input int enc, input logic [3:0] c, input logic [3:0] f,
                       input int fd, input int md);
        build(enc, c, f, fd, md);
        play(enc, c, f, 1000);
    endtask

    task automatic reset_seq();
        @(negedge clk);
        #2;
        moc   = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() == 22'd0) n_pass++;
        else $display("FAIL reset_immediate got %h want %h", dut_vec(), 22'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(exp_vec(0, 1'b0));
    endtask

    // Monitor: compares every cycle for which stimulus recorded an expectation.
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (dut_vec() == e) n_pass++;
                else $display("FAIL cycle_outputs t=%0t got %h want %h", $time, dut_vec(), e);
            end
        end
    end

    initial begin
        int enc;
        reset     = 1'b1;
        moc       = 1'b0;
        enc_state = '0;
        ir_cond   = '0;
        flags     = '0;
        repeat (3) @(negedge clk);
        reset_seq();

        run(10, 4'b1110, 4'b0000, 1, 0);
        run(20, 4'b1110, 4'b1010, 0, 3);
        run(30, 4'b0000, 4'b0000, 2, 0);
        run(30, 4'b0000, 4'b0100, 0, 0);
        run(7,  4'b1110, 4'b0000, 0, 0);
        run(13, 4'b1110, 4'b0000, 0, 0);
        run(14, 4'b1111, 4'b1111, 0, 0);
        run(25, 4'b1110, 4'b0000, 1, 2);
        run(14, 4'b1110, 4'b0000, 3, 0);

        // Abort an LDR in the middle of its memory wait.
        build(20, 4'b1110, 4'b0000, 0, 3);
        play(20, 4'b1110, 4'b0000, 7);
        reset_seq();

        for (int k = 0; k < 80; k++) begin
            if (rbit()) enc = int'($urandom_range(0, 63));
            else begin
                case ($urandom_range(0, 7))
                    0: enc = 10; 1: enc = 11; 2: enc = 12; 3: enc = 13;
                    4: enc = 14; 5: enc = 20; 6: enc = 25; default: enc = 30;
                endcase
            end
            run(enc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Long store wait: completes in the default build, trips the watchdog otherwise.
        run(25, 4'b1110, 4'b0000, 0, 20);
        reset_seq();
        run(10, 4'b1110, 4'b0000, 0, 0);

        @(negedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
